rf_wb_arbiter: RTL and testbench
================================

Name: rf_wb_arbiter

Overview:
- Shares the single integer register-file write port between N_REQ writeback requesters: ALU, LSU and MUL/DIV.
- Uses round-robin arbitration, one write per cycle, and a registered write stage with 1-cycle latency.
- Drives the decode stage's stall input when a writeback is held off, and keeps a saturating write-conflict counter for performance monitoring.

Parameters:
- N_REQ, 3, number of writeback requesters. Index 0 = ALU, 1 = LSU, 2 = MUL/DIV. Legal range 2..8.
- DATA_W, 32, register data width.
- ADDR_W, 5, register index width.
- CNT_W, 16, width of the conflict counter.

Ports:
- clk_i  in  1  core clock.
- rst_i  in  1  reset, synchronous, active-high.
- req_valid_i  in  N_REQ  per-requester write request.
- req_ready_o  out  N_REQ  per-requester accept, one-hot or zero.
- req_rd_i  in  N_REQ*ADDR_W  destination register per requester; requester i occupies slice [i*ADDR_W +: ADDR_W].
- req_data_i  in  N_REQ*DATA_W  write data per requester; requester i occupies slice [i*DATA_W +: DATA_W].
- rf_we_o  out  1  register-file write enable (registered).
- rf_waddr_o  out  ADDR_W  register-file write address (registered).
- rf_wdata_o  out  DATA_W  register-file write data (registered).
- grant_idx_o  out  $clog2(N_REQ)  index of the requester accepted in the previous cycle.
- hazard_stall_o  out  1  combinational; high when any valid request is not accepted this cycle.
- conflict_cnt_o  out  CNT_W  saturating count of cycles with more than one valid request.
- conflict_clr_i  in  1  synchronous clear of conflict_cnt_o.

Behaviour:
- Reset (rst_i=1 at a clk_i edge):
  - rf_we_o=0, rf_waddr_o=0, rf_wdata_o=0, grant_idx_o=0, conflict_cnt_o=0.
  - Round-robin pointer ptr resets to 0.
  - While rst_i is high, req_ready_o=0 and hazard_stall_o=0.
  - A request in flight when reset asserts is dropped; the requester re-presents it after reset.
- Arbitration (combinational): scan indices ptr, ptr+1, …, ptr+N_REQ-1 (mod N_REQ). The first index with req_valid_i high is granted; req_ready_o has that single bit set. No valid request means req_ready_o=0.
- Transfer: occurs on a clk_i edge when req_valid_i[i] and req_ready_o[i] are both high.
- Pointer update: after a transfer from index g, ptr <= (g+1) mod N_REQ, wrapping at N_REQ-1 to 0. With no transfer, ptr holds. Any requester therefore waits at most N_REQ-1 cycles.
- Write stage: a transfer at edge t gives rf_we_o=1 with the registered address/data during cycle t+1. grant_idx_o <= g on every transfer.
- Idle cycle: rf_we_o=0 in the following cycle; rf_waddr_o and rf_wdata_o hold their last values.
- x0 rule: a request with rd=0 is accepted normally and advances ptr. rf_we_o stays 0 for it; rf_waddr_o and rf_wdata_o still update.
- Requester protocol: once valid is asserted, valid, rd and data are held stable until accepted; withdrawal is not allowed. The bench asserts this. The arbiter has no internal queue.
- hazard_stall_o = OR over i of (req_valid_i[i] & ~req_ready_o[i]).
- Conflict counter:
  - Increments when popcount(req_valid_i) >= 2.
  - Saturates at 2^CNT_W-1 and does not wrap.
  - conflict_clr_i has priority over increment; a clear in a conflict cycle yields 0.
- Same-register conflict: two requesters targeting the same rd are serialised in arbitration order; the later write wins in the register file. Ordering between them is owned upstream.
- No combinational path from req_*_i to rf_*_o.

Decomposition:
- Shared package rv32_pkg:
  - WB_ALU=0, WB_LSU=1, WB_MULDIV=2.
  - typedef wb_req_t (rd, data).
  - Default N_REQ derived from the WB_* constants.
- Sub-module rr_arbiter:
  - Parameterised on N, generic and reusable.
  - Inputs: req vector, advance strobe.
  - Outputs: one-hot grant, grant index.
  - Owns ptr.
- rf_wb_arbiter adds the write register, x0 rule, stall output and conflict counter.

Test Plan:
- Reset, then valid ALU only, rd=5, data=0xDEADBEEF → req_ready_o=001 the same cycle; next cycle rf_we_o=1, rf_waddr_o=5, rf_wdata_o=0xDEADBEEF, grant_idx_o=0; hazard_stall_o=0.
- All three valid and held for 3 cycles, rd=1/2/3 → grants 0,1,2 in order; writes land t+1..t+3; hazard_stall_o=1 for the first two cycles; conflict_cnt_o=2.
- Continuous ALU and LSU requests for 8 cycles → grants alternate 0,1,0,1…; no requester waits more than 1 cycle.
- LSU request with rd=0, data=0x1234 → req_ready_o=010; next cycle rf_we_o=0; the following request from MUL/DIV is granted next (ptr=2).
- Force the counter to 0xFFFE, then 3 conflict cycles → saturates at 0xFFFF; conflict_clr_i in a conflict cycle → 0.
- rst_i asserted while MUL/DIV is valid and a write is pending → next cycle rf_we_o=0, req_ready_o=0, ptr=0; after deassert, the held request is granted and written once.

Source files
------------

// File: rtl/rv32_pkg.sv
// Shared integer-pipeline definitions: writeback requester indices,
// register-file geometry and the writeback request payload type.
package rv32_pkg;

    localparam int WB_ALU    = 0;
    localparam int WB_LSU    = 1;
    localparam int WB_MULDIV = 2;
    localparam int WB_N_REQ  = WB_MULDIV + 1;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       data;
    } wb_req_t;

endpackage

// File: rtl/rr_arbiter.sv
// Generic N-way round-robin arbiter. The search starts at ptr; after an
// accepted grant ptr moves to the slot just past the winner.
module rr_arbiter #(
    parameter int N = 3
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [N-1:0]         req_i,
    input  logic                 adv_i,
    output logic [N-1:0]         gnt_o,
    output logic [$clog2(N)-1:0] gnt_idx_o
);

    localparam int IDX_W = $clog2(N);

    logic [IDX_W-1:0] r_ptr;
    logic [IDX_W-1:0] w_j;
    logic             w_found;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        gnt_o     = '0;
        gnt_idx_o = '0;
        w_found   = 1'b0;
        w_j       = '0;
        for (int k = 0; k < N; k++) begin
            w_j = IDX_W'((int'(r_ptr) + k) % N);
            if (!w_found && req_i[w_j]) begin
                gnt_o[w_j] = 1'b1;
                gnt_idx_o  = w_j;
                w_found    = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_ptr <= '0;
        end else if (adv_i) begin
            r_ptr <= (gnt_idx_o == IDX_W'(N - 1)) ? '0 : gnt_idx_o + 1'b1;
        end
    end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Integer register-file writeback port arbiter: round-robin select, one
// registered write per cycle, decode stall output and conflict counter.
module rf_wb_arbiter
    import rv32_pkg::*;
#(
    parameter int N_REQ  = WB_N_REQ,
    parameter int DATA_W = XLEN,
    parameter int ADDR_W = REG_ADDR_W,
    parameter int CNT_W  = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [N_REQ-1:0]         req_valid_i,
    output logic [N_REQ-1:0]         req_ready_o,
    input  logic [N_REQ*ADDR_W-1:0]  req_rd_i,
    input  logic [N_REQ*DATA_W-1:0]  req_data_i,
    output logic                     rf_we_o,
    output logic [ADDR_W-1:0]        rf_waddr_o,
    output logic [DATA_W-1:0]        rf_wdata_o,
    output logic [$clog2(N_REQ)-1:0] grant_idx_o,
    output logic                     hazard_stall_o,
    output logic [CNT_W-1:0]         conflict_cnt_o,
    input  logic                     conflict_clr_i
);

    localparam int IDX_W = $clog2(N_REQ);

    logic [N_REQ-1:0]  w_gnt;
    logic [IDX_W-1:0]  w_gnt_idx;
    logic              w_xfer;
    logic              w_conflict;
    logic [ADDR_W-1:0] w_sel_rd;
    logic [DATA_W-1:0] w_sel_data;

    logic              r_we;
    logic [ADDR_W-1:0] r_waddr;
    logic [DATA_W-1:0] r_wdata;
    logic [IDX_W-1:0]  r_grant_idx;
    logic [CNT_W-1:0]  r_conflict_cnt;

    rr_arbiter #(
        .N (N_REQ)
    ) u_rr (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .req_i     (req_valid_i),
        .adv_i     (w_xfer),
        .gnt_o     (w_gnt),
        .gnt_idx_o (w_gnt_idx)
    );

    // Nobody is accepted while reset is held, so no request is consumed.
    assign req_ready_o    = rst_i ? '0 : w_gnt;
    assign w_xfer         = |req_ready_o;
    assign hazard_stall_o = |(req_valid_i & ~req_ready_o) & ~rst_i;
    assign w_conflict     = $countones(req_valid_i) >= 2;

    always_comb begin
        w_sel_rd   = '0;
        w_sel_data = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_gnt[i]) begin
                w_sel_rd   = req_rd_i[i*ADDR_W +: ADDR_W];
                w_sel_data = req_data_i[i*DATA_W +: DATA_W];
            end
        end
    end

    // Writes to x0 are accepted and recorded but never enabled.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_we        <= 1'b0;
            r_waddr     <= '0;
            r_wdata     <= '0;
            r_grant_idx <= '0;
        end else begin
            // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
            r_we <= w_xfer && (w_sel_rd != '0);
            if (w_xfer) begin
                r_waddr     <= w_sel_rd;
                r_wdata     <= w_sel_data;
                r_grant_idx <= w_gnt_idx;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || conflict_clr_i) begin
            r_conflict_cnt <= '0;
        end else if (w_conflict && (r_conflict_cnt != {CNT_W{1'b1}})) begin
            r_conflict_cnt <= r_conflict_cnt + 1'b1;
        end
    end

    assign rf_we_o        = r_we;
    assign rf_waddr_o     = r_waddr;
    assign rf_wdata_o     = r_wdata;
    assign grant_idx_o    = r_grant_idx;
    assign conflict_cnt_o = r_conflict_cnt;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed bench for rf_wb_arbiter: arbitration order, write stage, x0 rule,
// stall output, conflict counter saturation/clear and reset mid-flight.
module tb_rf_wb_arbiter;
    import rv32_pkg::*;

    localparam int N_REQ  = 3;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int CNT_W  = 16;

    logic                    clk_i = 1'b0;
    logic                    rst_i;
    logic [N_REQ-1:0]        req_valid_i;
    logic [N_REQ-1:0]        req_ready_o;
    logic [N_REQ*ADDR_W-1:0] req_rd_i;
    logic [N_REQ*DATA_W-1:0] req_data_i;
    logic                    rf_we_o;
    logic [ADDR_W-1:0]       rf_waddr_o;
    logic [DATA_W-1:0]       rf_wdata_o;
    logic [1:0]              grant_idx_o;
    logic                    hazard_stall_o;
    logic [CNT_W-1:0]        conflict_cnt_o;
    logic                    conflict_clr_i;

    int checks = 0;
    int errors = 0;

    always #5 clk_i = ~clk_i;

    rf_wb_arbiter #(
        .N_REQ  (N_REQ),
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .req_valid_i    (req_valid_i),
        .req_ready_o    (req_ready_o),
        .req_rd_i       (req_rd_i),
        .req_data_i     (req_data_i),
        .rf_we_o        (rf_we_o),
        .rf_waddr_o     (rf_waddr_o),
        .rf_wdata_o     (rf_wdata_o),
        .grant_idx_o    (grant_idx_o),
        .hazard_stall_o (hazard_stall_o),
        .conflict_cnt_o (conflict_cnt_o),
        .conflict_clr_i (conflict_clr_i)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic set_req(input int i, input logic v, input wb_req_t r);
        req_valid_i[i]                = v;
        req_rd_i[i*ADDR_W +: ADDR_W]  = r.rd;
        req_data_i[i*DATA_W +: DATA_W] = r.data;
    endtask

    task automatic drop(input int i);
        req_valid_i[i] = 1'b0;
    endtask

    task automatic check_wr(input string tag, input logic we, input logic [4:0] addr,
                            input logic [31:0] data, input logic [1:0] gidx);
        check({tag, ".we"},    rf_we_o,     we);
        check({tag, ".waddr"}, rf_waddr_o,  addr);
        check({tag, ".wdata"}, rf_wdata_o,  data);
        check({tag, ".gidx"},  grant_idx_o, gidx);
    endtask

    initial begin
        rst_i          = 1'b1;
        req_valid_i    = '0;
        req_rd_i       = '0;
        req_data_i     = '0;
        conflict_clr_i = 1'b0;

        // Reset state, and no accept/stall while reset is held.
        tick();
        tick();
        check_wr("rst", 1'b0, 5'd0, 32'h0, 2'd0);
        check("rst.cnt", conflict_cnt_o, 16'h0);
        set_req(WB_ALU, 1'b1, '{rd: 5'd3, data: 32'h1});
        settle();
        check("rst.ready", req_ready_o, 3'b000);
        check("rst.stall", hazard_stall_o, 1'b0);
        drop(WB_ALU);
        rst_i = 1'b0;

        // Single ALU write; ptr 0 -> 1.
        set_req(WB_ALU, 1'b1, '{rd: 5'd5, data: 32'hDEADBEEF});
        settle();
        check("alu.ready", req_ready_o, 3'b001);
        check("alu.stall", hazard_stall_o, 1'b0);
        tick();
        drop(WB_ALU);
        check_wr("alu.wr", 1'b1, 5'd5, 32'hDEADBEEF, 2'd0);

        // LSU write to x0: accepted, no write enable, ptr 1 -> 2.
        set_req(WB_LSU, 1'b1, '{rd: 5'd0, data: 32'h1234});
        settle();
        check("x0.ready", req_ready_o, 3'b010);
        check("x0.stall", hazard_stall_o, 1'b0);
        tick();
        drop(WB_LSU);
        check_wr("x0.wr", 1'b0, 5'd0, 32'h1234, 2'd1);

        // ALU and MUL/DIV together: ptr=2 gives MUL/DIV first.
        set_req(WB_ALU,    1'b1, '{rd: 5'd7, data: 32'hAAAA});
        set_req(WB_MULDIV, 1'b1, '{rd: 5'd9, data: 32'h9999});
        settle();
        check("ptr2.ready", req_ready_o, 3'b100);
        check("ptr2.stall", hazard_stall_o, 1'b1);
        tick();
        drop(WB_MULDIV);
        check_wr("ptr2.wr", 1'b1, 5'd9, 32'h9999, 2'd2);
        settle();
        check("ptr0.ready", req_ready_o, 3'b001);
        check("ptr0.stall", hazard_stall_o, 1'b0);
        tick();
        drop(WB_ALU);
        check_wr("ptr0.wr", 1'b1, 5'd7, 32'hAAAA, 2'd0);
        check("ptr0.cnt", conflict_cnt_o, 16'd1);

        // Clear in an idle cycle; write outputs hold on idle.
        conflict_clr_i = 1'b1;
        tick();
        conflict_clr_i = 1'b0;
        check("clr.cnt", conflict_cnt_o, 16'd0);
        check_wr("idle.wr", 1'b0, 5'd7, 32'hAAAA, 2'd0);

        // MUL/DIV alone from ptr=1 brings ptr back to 0.
        set_req(WB_MULDIV, 1'b1, '{rd: 5'd4, data: 32'h44});
        settle();
        check("md.ready", req_ready_o, 3'b100);
        tick();
        drop(WB_MULDIV);
        check_wr("md.wr", 1'b1, 5'd4, 32'h44, 2'd2);

        // All three held until accepted: grants 0,1,2.
        set_req(WB_ALU,    1'b1, '{rd: 5'd1, data: 32'h11});
        set_req(WB_LSU,    1'b1, '{rd: 5'd2, data: 32'h22});
        set_req(WB_MULDIV, 1'b1, '{rd: 5'd3, data: 32'h33});
        settle();
        check("all.c0.ready", req_ready_o, 3'b001);
        check("all.c0.stall", hazard_stall_o, 1'b1);
        tick();
        drop(WB_ALU);
        check_wr("all.w0", 1'b1, 5'd1, 32'h11, 2'd0);
        settle();
        check("all.c1.ready", req_ready_o, 3'b010);
        check("all.c1.stall", hazard_stall_o, 1'b1);
        tick();
        drop(WB_LSU);
        check_wr("all.w1", 1'b1, 5'd2, 32'h22, 2'd1);
        settle();
        check("all.c2.ready", req_ready_o, 3'b100);
        check("all.c2.stall", hazard_stall_o, 1'b0);
        tick();
        drop(WB_MULDIV);
        check_wr("all.w2", 1'b1, 5'd3, 32'h33, 2'd2);
        check("all.cnt", conflict_cnt_o, 16'd2);
        tick();
        check_wr("all.idle", 1'b0, 5'd3, 32'h33, 2'd2);

        // ALU and LSU continuously valid for 8 cycles from ptr=0: alternate.
        set_req(WB_ALU, 1'b1, '{rd: 5'd10, data: 32'hA0});
        set_req(WB_LSU, 1'b1, '{rd: 5'd20, data: 32'hB0});
        for (int k = 0; k < 8; k++) begin
            settle();
            check($sformatf("alt%0d.ready", k), req_ready_o, (k % 2 == 0) ? 3'b001 : 3'b010);
            check($sformatf("alt%0d.stall", k), hazard_stall_o, 1'b1);
            tick();
            check($sformatf("alt%0d.gidx", k), grant_idx_o, 2'(k % 2));
            check($sformatf("alt%0d.waddr", k), rf_waddr_o, (k % 2 == 0) ? 5'd10 : 5'd20);
        end
        drop(WB_ALU);
        drop(WB_LSU);
        check("alt.cnt", conflict_cnt_o, 16'd10);

        // Counter saturation and clear in a conflict cycle.
        conflict_clr_i = 1'b1;
        tick();
        conflict_clr_i = 1'b0;
        check("sat.clr0", conflict_cnt_o, 16'd0);
        set_req(WB_ALU,    1'b1, '{rd: 5'd1, data: 32'h11});
        set_req(WB_LSU,    1'b1, '{rd: 5'd2, data: 32'h22});
        set_req(WB_MULDIV, 1'b1, '{rd: 5'd3, data: 32'h33});
        repeat (16'hFFFE) tick();
        check("sat.fffe", conflict_cnt_o, 16'hFFFE);
        for (int k = 0; k < 3; k++) begin
            tick();
            check($sformatf("sat.ffff%0d", k), conflict_cnt_o, 16'hFFFF);
        end
        conflict_clr_i = 1'b1;
        tick();
        conflict_clr_i = 1'b0;
        check("sat.clr", conflict_cnt_o, 16'd0);
        tick();
        check("sat.after", conflict_cnt_o, 16'd1);
        drop(WB_ALU);
        drop(WB_LSU);
        drop(WB_MULDIV);
        tick();

        // Reset while a write is pending and MUL/DIV is valid.
        set_req(WB_ALU, 1'b1, '{rd: 5'd6, data: 32'h66});
        tick();
        drop(WB_ALU);
        set_req(WB_MULDIV, 1'b1, '{rd: 5'd8, data: 32'h88});
        rst_i = 1'b1;
        settle();
        check("rr.pend.we", rf_we_o, 1'b1);
        check("rr.ready", req_ready_o, 3'b000);
        check("rr.stall", hazard_stall_o, 1'b0);
        tick();
        check_wr("rr.rst", 1'b0, 5'd0, 32'h0, 2'd0);
        check("rr.cnt", conflict_cnt_o, 16'd0);
        rst_i = 1'b0;
        set_req(WB_ALU, 1'b1, '{rd: 5'd12, data: 32'hCC});
        settle();
        check("rr.ptr0.ready", req_ready_o, 3'b001);
        tick();
        drop(WB_ALU);
        check_wr("rr.w0", 1'b1, 5'd12, 32'hCC, 2'd0);
        settle();
        check("rr.md.ready", req_ready_o, 3'b100);
        tick();
        drop(WB_MULDIV);
        check_wr("rr.w1", 1'b1, 5'd8, 32'h88, 2'd2);
        tick();
        check("rr.once", rf_we_o, 1'b0);
        check("rr.cnt1", conflict_cnt_o, 16'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
